// File: rtl/ternary_vector_core.sv
`default_nettype none
// ternary_vector_core -- streaming ternary DOT/SUM/NZCNT engine with a two-stage per-lane accumulate.
// Optional macro TERNARY_VC_SAT_EN selects saturating accumulators (default: wrap-around). Rev 1.0
module ternary_vector_core #(
  parameter int LANES       = 16,
  parameter int ACCUM_WIDTH = 32,
  parameter int DEPTH       = 256,
  localparam int LW         = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [2:0]                   op_mode,
  input  logic [LW-1:0]                len,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*2-1:0]           bus_weights,
  input  logic [LANES*2-1:0]           bus_inputs,
  output logic [LW-1:0]                beat_idx,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*ACCUM_WIDTH-1:0] vector_out,
  output logic                         busy,
  output logic                         err
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  localparam logic [2:0]    OP_DOT   = 3'b001;
  localparam logic [2:0]    OP_SUM   = 3'b010;
  localparam logic [2:0]    OP_NZ    = 3'b100;
  localparam logic [LW-1:0] DEPTH_LW = LW'(DEPTH);
`ifdef TERNARY_VC_SAT_EN
  localparam logic [ACCUM_WIDTH-1:0] ACC_MAX = {1'b0, {(ACCUM_WIDTH-1){1'b1}}};
  localparam logic [ACCUM_WIDTH-1:0] ACC_MIN = {1'b1, {(ACCUM_WIDTH-1){1'b0}}};
`endif

  state_t                              state_q, state_d;
  logic [2:0]                          op_q, op_d;
  logic [LW-1:0]                       remaining_q, remaining_d;
  logic [LW-1:0]                       beat_idx_q, beat_idx_d;
  logic                                err_q, err_d;
  logic [LANES-1:0][1:0]               term_q, term_d;
  logic [LANES-1:0][ACCUM_WIDTH-1:0]   acc_q, acc_d;

  logic                  legal_op;
  logic                  beat_bad;
  logic [LW-1:0]         len_clamped;
  logic [LANES-1:0][1:0] beat_term;

  function automatic logic signed [1:0] trit(input logic [1:0] c);
    case (c)
      2'b01:   trit = 2'sd1;
      2'b10:   trit = -2'sd1;
      default: trit = 2'sd0;
    endcase
  endfunction

  // Terms are always in {-1,0,+1}, so a signed 2-bit code carries them between stages.
  function automatic logic [1:0] term_of(input logic [2:0] op, input logic [1:0] wc,
                                         input logic [1:0] xc);
    logic signed [1:0] w;
    logic signed [1:0] x;
    logic signed [1:0] p;
    w = trit(wc);
    x = trit(xc);
    if (w == 2'sd0 || x == 2'sd0) p = 2'sd0;
    else if (w == x)              p = 2'sd1;
    else                          p = -2'sd1;
    case (op)
      OP_DOT:  term_of = p;
      OP_SUM:  term_of = x;
      OP_NZ:   term_of = (p != 2'sd0) ? 2'b01 : 2'b00;
      default: term_of = 2'b00;
    endcase
  endfunction

  function automatic logic [ACCUM_WIDTH-1:0] acc_add(input logic [ACCUM_WIDTH-1:0] a,
                                                     input logic [1:0] t);
`ifdef TERNARY_VC_SAT_EN
    logic [ACCUM_WIDTH:0] s;
    s = {a[ACCUM_WIDTH-1], a} + {{(ACCUM_WIDTH-1){t[1]}}, t};
    if (s[ACCUM_WIDTH] != s[ACCUM_WIDTH-1]) acc_add = s[ACCUM_WIDTH] ? ACC_MIN : ACC_MAX;
    else                                     acc_add = s[ACCUM_WIDTH-1:0];
`else
    acc_add = a + {{(ACCUM_WIDTH-2){t[1]}}, t};
`endif
  endfunction

  always_comb begin
    legal_op    = (op_mode == OP_DOT) || (op_mode == OP_SUM) || (op_mode == OP_NZ);
    len_clamped = (len > DEPTH_LW) ? DEPTH_LW : len;
    beat_bad    = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      beat_term[l] = term_of(op_q, bus_weights[2*l +: 2], bus_inputs[2*l +: 2]);
      beat_bad     = beat_bad | (&bus_weights[2*l +: 2]) | (&bus_inputs[2*l +: 2]);
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    remaining_d = remaining_q;
    beat_idx_d  = beat_idx_q;
    err_d       = err_q;
    term_d      = '0;
    // Stage 2 runs every cycle; idle cycles simply add a zero term.
    for (int l = 0; l < LANES; l++) acc_d[l] = acc_add(acc_q[l], term_q[l]);

    case (state_q)
      IDLE: begin
        if (start) begin
          if (legal_op) begin
            op_d        = op_mode;
            remaining_d = len_clamped;
            beat_idx_d  = '0;
            err_d       = 1'b0;
            acc_d       = '0;
            state_d     = (len_clamped == '0) ? DRAIN : RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (in_valid) begin
          term_d      = beat_term;
          beat_idx_d  = beat_idx_q + LW'(1);
          remaining_d = remaining_q - LW'(1);
          if (beat_bad) err_d = 1'b1;
          if (remaining_q == LW'(1)) state_d = DRAIN;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      remaining_q <= '0;
      beat_idx_q  <= '0;
      err_q       <= 1'b0;
      term_q      <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      remaining_q <= remaining_d;
      beat_idx_q  <= beat_idx_d;
      err_q       <= err_d;
      term_q      <= term_d;
      acc_q       <= acc_d;
    end
  end

  assign in_ready   = (state_q == RUN);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign err        = err_q;
  assign beat_idx   = beat_idx_q;
  assign vector_out = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_ternary_vector_core.sv
`default_nettype none
// tb_ternary_vector_core -- randomized bench with a lane-level arithmetic reference model.
module tb_ternary_vector_core;
  localparam int LANES = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int AMAX  = (1 << (AW - 1)) - 1;
  localparam int AMIN  = -(1 << (AW - 1));

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic [2:0]            op_mode;
  logic [LW-1:0]         len;
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*2-1:0]    bus_weights;
  logic [LANES*2-1:0]    bus_inputs;
  logic [LW-1:0]         beat_idx;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*AW-1:0]   vector_out;
  logic                  busy;
  logic                  err;

  ternary_vector_core #(.LANES(LANES), .ACCUM_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .op_mode(op_mode), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .bus_weights(bus_weights),
    .bus_inputs(bus_inputs), .beat_idx(beat_idx), .out_valid(out_valid),
    .out_ready(out_ready), .vector_out(vector_out), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [LANES*2-1:0] wts [DEPTH];
  logic [LANES*2-1:0] ins [DEPTH];
  int                 macc [LANES];
  bit                 merr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int dec(input logic [1:0] c);
    if (c == 2'b01) return 1;
    if (c == 2'b10) return -1;
    return 0;
  endfunction

  function automatic int term(input logic [2:0] op, input logic [1:0] wc, input logic [1:0] xc);
    int p;
    p = dec(wc) * dec(xc);
    case (op)
      3'b001:  return p;
      3'b010:  return dec(xc);
      3'b100:  return (p != 0) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic int fit(input int v);
`ifdef TERNARY_VC_SAT_EN
    if (v > AMAX) return AMAX;
    if (v < AMIN) return AMIN;
    return v;
`else
    return ((v - AMIN) % (1 << AW) + (1 << AW)) % (1 << AW) + AMIN;
`endif
  endfunction

  function automatic logic [1:0] rand_code();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 2'b11;
    case (r % 3)
      0:       return 2'b00;
      1:       return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  task automatic fill_random();
    for (int d = 0; d < DEPTH; d++)
      for (int l = 0; l < LANES; l++) begin
        wts[d][2*l +: 2] = rand_code();
        ins[d][2*l +: 2] = rand_code();
      end
  endtask

  // vmode: 0 = in_valid always high, 1 = alternate 1/0, 2 = random bubbles.
  task automatic run_cmd(input logic [2:0] op, input int ln, input int vmode, input int hold);
    int n, got, cyc;
    logic v;
    logic [LANES*AW-1:0] ev;
    n = (ln > DEPTH) ? DEPTH : ln;
    for (int l = 0; l < LANES; l++) macc[l] = 0;
    merr = 1'b0;
    start = 1'b1; op_mode = op; len = LW'(ln);
    tick();
    start = 1'b0; op_mode = 3'($urandom); len = LW'($urandom);
    check("busy_after_start", busy, 1'b1);
    check("err_cleared", err, 1'b0);
    got = 0; cyc = 0;
    while (got < n && cyc < 200) begin
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
      in_valid = v;
      if (v) begin
        bus_weights = wts[got];
        bus_inputs  = ins[got];
      end else begin
        bus_weights = 8'($urandom);
        bus_inputs  = 8'($urandom);
      end
      check("in_ready_run", in_ready, 1'b1);
      check("beat_idx", beat_idx, 64'(got));
      tick();
      cyc++;
      if (v) begin
        for (int l = 0; l < LANES; l++) begin
          macc[l] = fit(macc[l] + term(op, wts[got][2*l +: 2], ins[got][2*l +: 2]));
          if (wts[got][2*l +: 2] == 2'b11 || ins[got][2*l +: 2] == 2'b11) merr = 1'b1;
        end
        got++;
      end
    end
    if (got < n) check("beat_timeout", 64'(got), 64'(n));
    if (vmode == 0) check("beat_cycles", 64'(cyc), 64'(n));
    in_valid = 1'($urandom); bus_weights = 8'($urandom); bus_inputs = 8'($urandom);
    check("in_ready_drain", in_ready, 1'b0);
    check("beat_idx_final", beat_idx, 64'(n));
    cyc = 0;
    while (!out_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    check("result_latency", 64'(cyc), 64'd1);
    for (int l = 0; l < LANES; l++) ev[l*AW +: AW] = AW'(macc[l]);
    check("vector_out", vector_out, ev);
    check("err_result", err, merr);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom); bus_weights = 8'($urandom); bus_inputs = 8'($urandom);
      tick();
      check("hold_valid", out_valid, 1'b1);
      check("hold_vector", vector_out, ev);
    end
    check("err_hold", err, merr);
    out_ready = 1'b1; start = 1'b1; op_mode = 3'b001; len = LW'(3);
    tick();
    start = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    check("valid_after_handshake", out_valid, 1'b0);
    check("busy_after_handshake", busy, 1'b0);
    check("vector_kept", vector_out, ev);
  endtask

  initial begin
    logic [2:0] ops [3];
    ops[0] = 3'b001; ops[1] = 3'b010; ops[2] = 3'b100;
    reset = 1'b0; start = 1'b0; op_mode = '0; len = '0; in_valid = 1'b0;
    bus_weights = '0; bus_inputs = '0; out_ready = 1'b0;
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_beat_idx", beat_idx, '0);
    check("rst_vector", vector_out, '0);
    reset = 1'b1;
    tick();

    // DOT, weights +1, inputs {+1,-1,0,+1}
    for (int d = 0; d < DEPTH; d++) begin wts[d] = 8'b01_01_01_01; ins[d] = 8'b01_00_10_01; end
    run_cmd(3'b001, 3, 0, 0);
    check("dot_directed", vector_out, 16'h30D3);

    fill_random();
    run_cmd(3'b010, 2, 1, 2);

    // NZCNT with lane 2 carrying an invalid code on beat 2
    for (int d = 0; d < DEPTH; d++) begin wts[d] = 8'b01_01_01_01; ins[d] = 8'b01_01_01_01; end
    ins[2] = 8'b01_11_01_01;
    run_cmd(3'b100, 4, 0, 1);
    check("nz_directed", vector_out, 16'h4344);
    check("nz_err", err, 1'b1);

    start = 1'b1; op_mode = 3'b011; len = LW'(4);
    tick();
    start = 1'b0;
    check("illegal_busy", busy, 1'b0);
    check("illegal_err", err, 1'b1);
    check("illegal_in_ready", in_ready, 1'b0);
    run_cmd(3'b001, 0, 0, 0);
    check("len0_zero", vector_out, '0);

    for (int d = 0; d < DEPTH; d++) begin wts[d] = 8'b01_01_01_01; ins[d] = 8'b01_01_01_01; end
    run_cmd(3'b001, 10, 0, 0);
`ifdef TERNARY_VC_SAT_EN
    check("dot_len10", vector_out, 16'h7777);
`else
    check("dot_len10", vector_out, 16'hAAAA);
`endif
    for (int d = 0; d < DEPTH; d++) begin wts[d] = 8'b10_01_10_01; ins[d] = 8'b10_10_01_01; end
    run_cmd(3'b001, 20, 0, 0);

    for (int it = 0; it < 25; it++) begin
      fill_random();
      run_cmd(ops[$urandom_range(0, 2)], $urandom_range(0, 20), $urandom_range(0, 2),
              $urandom_range(0, 3));
    end

    // Reset while the fifth of eight beats is being presented
    fill_random();
    start = 1'b1; op_mode = 3'b001; len = LW'(8);
    tick();
    start = 1'b0; in_valid = 1'b1;
    for (int d = 0; d < 4; d++) begin
      bus_weights = wts[d]; bus_inputs = ins[d];
      tick();
    end
    bus_weights = wts[4]; bus_inputs = ins[4];
    #2 reset = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_beat_idx", beat_idx, '0);
    check("midrst_vector", vector_out, '0);
    check("midrst_err", err, 1'b0);
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_idle", busy, 1'b0);
    fill_random();
    run_cmd(3'b001, 1, 0, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/ternary_vector_core.md
# ternary_vector_core

Streaming, parametrised successor to the fixed-width ternary SIMD engine. Accepts a command (op, tile length), consumes `len` beats of LANES-wide 2-bit trit weights and inputs over a valid/ready handshake, accumulates per lane through a two-stage pipeline, and presents the lane accumulators under an output valid/ready handshake. Sits between the PT-5 unpack/bus controller (upstream) and the result writeback path (downstream). Beat `d`, lane `l` maps to logical offset `d*LANES + l`.

## Interface
- LANES, 16, SIMD lane count (≥1)
- ACCUM_WIDTH, 32, signed accumulator width per lane (≥4)
- DEPTH, 256, maximum beats per command (≥1); LW = $clog2(DEPTH+1)

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  command strobe, sampled in IDLE only
- op_mode  in  3  001=DOT, 010=SUM, 100=NZCNT; others illegal
- len  in  LW  beats in command; values >DEPTH clamp to DEPTH
- in_valid  in  1  beat valid
- in_ready  out  1  core accepts beat
- bus_weights  in  LANES*2  trit per lane, bits [2l+1:2l]
- bus_inputs  in  LANES*2  trit per lane
- beat_idx  out  LW  index `d` of next beat to accept
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- vector_out  out  LANES*ACCUM_WIDTH  signed accumulators, lane l at [l*ACCUM_WIDTH +: ACCUM_WIDTH]
- busy  out  1  state != IDLE
- err  out  1  sticky error flag

## Operation
- Trit encoding: 00=0, 01=+1, 10=−1, 11=invalid (treated as 0, sets err).
- Per lane per beat: DOT term = w*x; SUM term = x; NZCNT term = (w*x != 0) ? 1 : 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start with legal op → latch op, load remaining = min(len, DEPTH), clear all accumulators, clear err, beat_idx=0; go RUN if remaining>0 else DRAIN. start with illegal op → ignored, err=1, stay IDLE.
- RUN: in_ready=1. Beat accepted when in_valid&&in_ready; term registered (stage 1), added to accumulator next cycle (stage 2); beat_idx increments. After last beat accepted → DRAIN.
- DRAIN: one cycle; stage-2 add of the final beat completes. → DONE.
- DONE: out_valid=1; vector_out stable. out_valid&&out_ready → IDLE.
- start outside IDLE ignored; op_mode/len only sampled with accepted start.
- in_ready=0 in IDLE, DRAIN, DONE; in_valid there is ignored.
- Accumulator arithmetic: signed, ACCUM_WIDTH bits; overflow per Configuration.
- err: set by illegal-op start or any accepted beat containing code 11 in any weight or input lane; cleared only by an accepted legal start.

## Timing
- Reset (asserted low, asynchronous): state=IDLE, in_ready=0, out_valid=0, busy=0, err=0, beat_idx=0, vector_out=0, pipeline stage cleared.
- Reset deassertion mid-command: no resumption; core is in IDLE.
- Command with len=N, in_valid held high: start at edge 0; beats accepted at edges 1..N; DRAIN at edge N+1; out_valid high from after edge N+1 until the out_ready handshake edge. Result latency = N+2 cycles from start.
- len=0: IDLE→DRAIN→DONE; out_valid after 2 edges, vector_out all zero.
- Bubbles (in_valid low) stall beat count; stage 1 inserts zero term.
- out_ready held high in DONE: out_valid high exactly one cycle; start in that same cycle is ignored (state still DONE).
- busy combinational from state.

## Configuration
- TERNARY_VC_SAT_EN defined: each accumulator add saturates to [−2^(ACCUM_WIDTH−1), 2^(ACCUM_WIDTH−1)−1]; once clamped, a lane remains clamped until an opposite term moves it inward.
- Undefined: two's-complement wrap-around, no clamping.

## Test plan
- LANES=4, DOT, len=3, weights all +1, inputs per beat {+1,−1,0,+1} → out_valid at cycle 5, vector_out lanes {3,−3,0,3}.
- SUM, len=2, in_valid toggling 1-0-1-0-1 → exactly 2 beats counted, beat_idx 0→1→2, lanes equal sum of inputs, in_ready low after second beat.
- NZCNT, len=4, one lane carrying code 11 on beat 2 → that lane counts 3, err=1 at result; next legal start clears err.
- start with op_mode=011 → stays IDLE, busy=0, err=1; len=0 DOT → out_valid after 2 cycles, all zeros.
- ACCUM_WIDTH=4, DOT, len=10 all +1×+1 → with TERNARY_VC_SAT_EN lanes = 7; without, lanes = −6 (wrap).
- Reset asserted during RUN beat 5 of 8 → all outputs zero immediately; after release, new len=1 command yields correct single-beat result; out_ready held low keeps out_valid and vector_out stable for 10 cycles.
